// File: rtl/column_ram_arbiter_pkg.sv
// Shared types and constants for the column store write-port arbiter.
// FSM encoding and store geometry.
package column_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam int SLOTS     = 4;
  localparam int SEL_W     = 4;
  localparam int SLOT_W    = 2;
  localparam int DEF_COL_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last winner.
// Reusable for any shared ant-farm resource.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int j;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        winner = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/column_ram_arbiter.sv
// Write-port sequencer for the 4-slot column store: round-robin agent
// writes plus a 4-cycle clear sweep, all outputs registered.
module column_ram_arbiter
  import column_ram_arbiter_pkg::*;
#(
  parameter int                NUM_REQ   = 4,
  parameter int                COL_W     = DEF_COL_W,
  parameter logic [COL_W-1:0]  CLEAR_VAL = '0
) (
  input  logic                     inClk,
  input  logic                     inRst,
  input  logic [NUM_REQ-1:0]       inReq,
  input  logic [2*NUM_REQ-1:0]     inReqSel,
  input  logic [COL_W*NUM_REQ-1:0] inReqCol,
  input  logic                     inClear,
  output logic [NUM_REQ-1:0]       outGrant,
  output logic [SEL_W-1:0]         outSelW,
  output logic [COL_W-1:0]         outColW,
  output logic                     outW,
  output logic                     outBusy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t            state;
  logic [SLOT_W-1:0] cnt;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  win;
  logic              win_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (inReq),
    .last   (last),
    .winner (win),
    .valid  (win_valid)
  );

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
      outGrant <= '0;
      outW     <= 1'b0;
      outSelW  <= '0;
      outColW  <= '0;
      outBusy  <= 1'b0;
    end else begin
      outGrant <= '0;
      unique case (state)
        S_IDLE: begin
          if (inClear) begin
            state   <= S_CLEAR;
            cnt     <= '0;
            outW    <= 1'b1;
            outSelW <= '0;
            outColW <= CLEAR_VAL;
            outBusy <= 1'b1;
          end else if (win_valid) begin
            state    <= S_WRITE;
            last     <= win;
            outW     <= 1'b1;
            outGrant <= NUM_REQ'(1) << win;
            outSelW  <= {2'b00, inReqSel[2*int'(win) +: 2]};
            outColW  <= inReqCol[COL_W*int'(win) +: COL_W];
            outBusy  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (inClear) begin
            state   <= S_CLEAR;
            cnt     <= '0;
            outW    <= 1'b1;
            outSelW <= '0;
            outColW <= CLEAR_VAL;
            outBusy <= 1'b1;
          end else begin
            state   <= S_IDLE;
            outW    <= 1'b0;
            outBusy <= 1'b0;
          end
        end
        S_CLEAR: begin
          // Re-asserted clear is ignored here; IDLE picks it up afterwards.
          if (cnt == 2'd3) begin
            state   <= S_IDLE;
            outW    <= 1'b0;
            outBusy <= 1'b0;
          end else begin
            cnt     <= cnt + 2'd1;
            outSelW <= {2'b00, cnt + 2'd1};
          end
        end
        default: begin
          state   <= S_IDLE;
          outW    <= 1'b0;
          outBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_ram_arbiter.sv
// Bench for column_ram_arbiter: table of single requests plus
// hand sequences, all store writes checked through a scoreboard queue.
module tb_column_ram_arbiter;

  localparam int N = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [2*N-1:0] req_sel;
  logic [CW*N-1:0] req_col;
  logic          clr;
  logic [N-1:0]  grant;
  logic [3:0]    sel_w;
  logic [CW-1:0] col_w;
  logic          w;
  logic          busy;

  int checks;
  int failures;

  typedef struct {
    logic [N-1:0]  grant;
    logic [3:0]    sel;
    logic [CW-1:0] col;
  } wr_t;

  typedef struct {
    int            agent;
    logic [1:0]    sel;
    logic [CW-1:0] col;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[4];

  column_ram_arbiter #(
    .NUM_REQ   (N),
    .COL_W     (CW),
    .CLEAR_VAL ('0)
  ) dut (
    .inClk    (clk),
    .inRst    (rst),
    .inReq    (req),
    .inReqSel (req_sel),
    .inReqCol (req_col),
    .inClear  (clr),
    .outGrant (grant),
    .outSelW  (sel_w),
    .outColW  (col_w),
    .outW     (w),
    .outBusy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every store write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (w === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got grant=%b sel=%0d col=%0d",
                 grant, sel_w, col_w);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (grant !== e.grant || sel_w !== e.sel || col_w !== e.col) begin
          failures++;
          $display("FAIL write got grant=%b sel=%0d col=%0d want grant=%b sel=%0d col=%0d",
                   grant, sel_w, col_w, e.grant, e.sel, e.col);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int agent, input logic [1:0] s,
                         input logic [CW-1:0] c);
    wr_t e;
    e.grant = (agent < 0) ? '0 : (N'(1) << agent);
    e.sel   = {2'b00, s};
    e.col   = c;
    sb.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 4; i++) push_wr(-1, 2'(i), '0);
  endtask

  task automatic set_agent(input int a, input logic [1:0] s,
                           input logic [CW-1:0] c);
    req[a] = 1'b1;
    req_sel[2*a +: 2] = s;
    req_col[CW*a +: CW] = c;
  endtask

  // Drop the agent's request while its grant pulse is visible.
  task automatic wait_grant(input int a, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (grant[a] === 1'b1) begin
        req[a] = 1'b0;
        found = 1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL grant_timeout agent=%0d", a);
      req[a] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req = '0;
    req_sel = '0;
    req_col = '0;
    clr = 1'b0;

    vecs[0] = '{agent: 2, sel: 2'd1, col: 3'd5};
    vecs[1] = '{agent: 0, sel: 2'd3, col: 3'd7};
    vecs[2] = '{agent: 3, sel: 2'd2, col: 3'd2};
    vecs[3] = '{agent: 1, sel: 2'd0, col: 3'd1};

    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_w", 32'(w), 0);
    chk("rst_sel", 32'(sel_w), 0);
    chk("rst_col", 32'(col_w), 0);
    chk("rst_busy", 32'(busy), 0);

    // Round robin from reset: 0,1,2,3,0 at one write per two cycles.
    for (int a = 0; a < N; a++) set_agent(a, 2'(a), CW'(a + 1));
    for (int k = 0; k < 5; k++) push_wr(k % N, 2'(k % N), CW'((k % N) + 1));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_write_cycle", 32'(w), 1);
      tick();
      chk("rr_idle_cycle", 32'(w), 0);
    end
    req = '0;

    // Single-request table.
    for (int v = 0; v < 4; v++) begin
      set_agent(vecs[v].agent, vecs[v].sel, vecs[v].col);
      push_wr(vecs[v].agent, vecs[v].sel, vecs[v].col);
      tick();
      chk("single_busy_write", 32'(busy), 1);
      req = '0;
      tick();
      chk("single_busy_after", 32'(busy), 0);
      chk("single_w_after", 32'(w), 0);
    end

    // Same slot: last winner is 1, so agent 3 goes first, then agent 1.
    set_agent(1, 2'd2, 3'd6);
    set_agent(3, 2'd2, 3'd3);
    push_wr(3, 2'd2, 3'd3);
    push_wr(1, 2'd2, 3'd6);
    wait_grant(3, 4);
    wait_grant(1, 4);
    tick();

    // Plain clear sweep.
    push_sweep();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    chk("sweep_busy_last", 32'(busy), 1);
    tick();
    chk("sweep_w_done", 32'(w), 0);
    chk("sweep_busy_done", 32'(busy), 0);

    // Case A: clear beats agent 1 in the same IDLE sample.
    push_sweep();
    push_wr(1, 2'd3, 3'd4);
    set_agent(1, 2'd3, 3'd4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("caseA_no_grant", 32'(grant), 0);
    wait_grant(1, 8);
    tick();

    // Case B: clear raised during agent 0's write.
    set_agent(0, 2'd1, 3'd2);
    push_wr(0, 2'd1, 3'd2);
    tick();
    req = '0;
    clr = 1'b1;
    push_sweep();
    tick();
    clr = 1'b0;
    chk("caseB_sweep_start", 32'(busy), 1);
    repeat (4) tick();
    chk("caseB_done", 32'(busy), 0);

    // Mid-sweep reset: only two sweep writes land, then agent 0 wins.
    push_wr(-1, 2'd0, '0);
    push_wr(-1, 2'd1, '0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_w", 32'(w), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    set_agent(0, 2'd2, 3'd1);
    set_agent(2, 2'd3, 3'd6);
    push_wr(0, 2'd2, 3'd1);
    push_wr(2, 2'd3, 3'd6);
    wait_grant(0, 4);
    wait_grant(2, 4);
    repeat (3) tick();

    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
